// File: rtl/msx_clock_reset_seq.sv
// msx_clock_reset_seq
//   Reset sequencer and clock-enable generator for the MSX core. Sits right
//   after the PLL wrapper. It waits for a stable PLL lock, releases the SDRAM
//   controller, waits for SDRAM init (or a timeout), then releases the core
//   and generates single-cycle enables on the single 21.477 MHz clock.
//
//   Optional feature macro: MSX_TURBO_EN (adds the turbo input; Z80 enable
//   doubles to 7.16 MHz, switching only on 12-cycle window boundaries).
//
// Ports
//   clk              in   21.477 MHz master clock (PLL outclk_0)
//   rst              in   asynchronous active-high reset of the whole block
//   pll_locked       in   PLL locked flag, asynchronous to clk
//   reset_button     in   user reset request, active-high, asynchronous
//   turbo            in   (MSX_TURBO_EN only) turbo request, asynchronous
//   sdram_init_done  in   SDRAM controller init finished, synchronous
//   sdram_reset      out  SDRAM controller reset, active-high
//   sys_reset        out  MSX core reset, active-high
//   ce_10m7          out  enable, 1 of 2 cycles
//   ce_5m37          out  VDP pixel enable, 1 of 4 cycles
//   ce_cpu           out  Z80 enable, 1 of 6 cycles (1 of 3 in turbo)
//   ce_1m79          out  PSG enable, 1 of 12 cycles
//   state_o          out  current sequencer state (debug)
module msx_clock_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SDRAM_TIMEOUT      = 65535,
  parameter int BUTTON_STRETCH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       reset_button,
`ifdef MSX_TURBO_EN
  input  logic       turbo,
`endif
  input  logic       sdram_init_done,
  output logic       sdram_reset,
  output logic       sys_reset,
  output logic       ce_10m7,
  output logic       ce_5m37,
  output logic       ce_cpu,
  output logic       ce_1m79,
  output logic [1:0] state_o
);

  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(SDRAM_TIMEOUT + 1);
  localparam int BW = $clog2(BUTTON_STRETCH + 1);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(SDRAM_TIMEOUT);
  localparam logic [BW-1:0] STRETCH_LOAD = BW'(BUTTON_STRETCH);

  typedef enum logic [1:0] {
    LOCK_WAIT  = 2'd0,
    SDRAM_WAIT = 2'd1,
    RUN        = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizers for the asynchronous inputs (bit 0 = lock,
  // bit 1 = button).
  // ---------------------------------------------------------------------
  logic [1:0] async_in;
  logic [1:0] sync_s;

  assign async_in = {reset_button, pll_locked};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic s_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_reg <= 1'b0;
        s_reg    <= 1'b0;
      end else begin
        meta_reg <= async_in[gi];
        s_reg    <= meta_reg;
      end
    end
    assign sync_s[gi] = s_reg;
  end

  logic locked_s;
  logic btn_s;
  assign locked_s = sync_s[0];
  assign btn_s    = sync_s[1];

  // ---------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [LW-1:0]   stable_cnt_reg, stable_cnt_next;
  logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;
  logic [BW-1:0]   stretch_cnt_reg, stretch_cnt_next;
  logic [3:0]      div_reg, div_next;

  logic sdram_reset_reg, sys_reset_reg;
  logic ce_10m7_reg, ce_5m37_reg, ce_cpu_reg, ce_1m79_reg;

  logic run_next;
  logic cpu_hit;

`ifdef MSX_TURBO_EN
  // The turbo request gets one meta flop; the mode register itself is the
  // second stage, and it only loads at the start of a 12-cycle window so
  // the Z80 enable pattern never changes mid-window.
  logic turbo_meta_reg;
  logic turbo_mode_reg, turbo_mode_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turbo_meta_reg <= 1'b0;
      turbo_mode_reg <= 1'b0;
    end else begin
      turbo_meta_reg <= turbo;
      turbo_mode_reg <= turbo_mode_next;
    end
  end
`endif

  // Next-state and counter logic
  always_comb begin
    state_next       = state_reg;
    stable_cnt_next  = '0;
    timeout_cnt_next = '0;
    case (state_reg)
      LOCK_WAIT: begin
        if (locked_s) begin
          if (stable_cnt_reg == LOCK_LAST) begin
            state_next = SDRAM_WAIT;
          end else begin
            stable_cnt_next = stable_cnt_reg + 1'b1;
          end
        end
      end
      SDRAM_WAIT: begin
        // Lock loss wins over both exits.
        if (!locked_s) begin
          state_next = LOCK_WAIT;
        end else if (sdram_init_done || (timeout_cnt_reg == TIMEOUT_LAST)) begin
          state_next = RUN;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = LOCK_WAIT;
        end
      end
      default: begin
        state_next = LOCK_WAIT;
      end
    endcase
  end

  assign run_next = (state_next == RUN);

  // Button stretch and enable divider
  always_comb begin
    stretch_cnt_next = '0;
    div_next         = 4'd0;
    if (run_next) begin
      // The counter reloads every cycle the button is seen high, so a held
      // button keeps the core in reset and the stretch runs from release.
      if ((state_reg == RUN) && btn_s) begin
        stretch_cnt_next = STRETCH_LOAD;
      end else if (stretch_cnt_reg != '0) begin
        stretch_cnt_next = stretch_cnt_reg - 1'b1;
      end
      if (state_reg == RUN) begin
        div_next = (div_reg == 4'd11) ? 4'd0 : div_reg + 4'd1;
      end
    end
  end

`ifdef MSX_TURBO_EN
  always_comb begin
    turbo_mode_next = turbo_mode_reg;
    if (run_next && (div_next == 4'd0)) begin
      turbo_mode_next = turbo_meta_reg;
    end
    if (turbo_mode_next) begin
      cpu_hit = (div_next == 4'd0) || (div_next == 4'd3) ||
                (div_next == 4'd6) || (div_next == 4'd9);
    end else begin
      cpu_hit = (div_next == 4'd0) || (div_next == 4'd6);
    end
  end
`else
  assign cpu_hit = (div_next == 4'd0) || (div_next == 4'd6);
`endif

  // Registers. Outputs are decoded from next-state values so that each
  // registered output lines up with the state the sequencer is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= LOCK_WAIT;
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      stretch_cnt_reg <= '0;
      div_reg         <= 4'd0;
      sdram_reset_reg <= 1'b1;
      sys_reset_reg   <= 1'b1;
      ce_10m7_reg     <= 1'b0;
      ce_5m37_reg     <= 1'b0;
      ce_cpu_reg      <= 1'b0;
      ce_1m79_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stable_cnt_reg  <= stable_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      stretch_cnt_reg <= stretch_cnt_next;
      div_reg         <= div_next;
      sdram_reset_reg <= (state_next != SDRAM_WAIT) && (state_next != RUN);
      sys_reset_reg   <= !run_next || (stretch_cnt_next != '0);
      ce_10m7_reg     <= run_next && (div_next[0] == 1'b0);
      ce_5m37_reg     <= run_next && (div_next[1:0] == 2'b00);
      ce_cpu_reg      <= run_next && cpu_hit;
      ce_1m79_reg     <= run_next && (div_next == 4'd0);
    end
  end

  assign sdram_reset = sdram_reset_reg;
  assign sys_reset   = sys_reset_reg;
  assign ce_10m7     = ce_10m7_reg;
  assign ce_5m37     = ce_5m37_reg;
  assign ce_cpu      = ce_cpu_reg;
  assign ce_1m79     = ce_1m79_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_msx_clock_reset_seq.sv
// tb_msx_clock_reset_seq
//   Scoreboard bench for msx_clock_reset_seq. The stimulus process drives
//   inputs at the falling edge and pushes the expected output of the coming
//   cycle, computed from an event-level model (lock streaks, phase entry
//   times, last button time). A monitor pops one entry per cycle just after
//   the rising edge and compares.
`timescale 1ns/1ps
module tb_msx_clock_reset_seq;

  localparam int LSC  = 8;
  localparam int TMO  = 20;
  localparam int BST  = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic reset_button = 1'b0;
  logic sdram_init_done = 1'b0;
`ifdef MSX_TURBO_EN
  logic turbo = 1'b0;
`endif
  logic sdram_reset, sys_reset, ce_10m7, ce_5m37, ce_cpu, ce_1m79;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  msx_clock_reset_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .SDRAM_TIMEOUT(TMO),
    .BUTTON_STRETCH(BST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .reset_button(reset_button),
`ifdef MSX_TURBO_EN
    .turbo(turbo),
`endif
    .sdram_init_done(sdram_init_done),
    .sdram_reset(sdram_reset),
    .sys_reset(sys_reset),
    .ce_10m7(ce_10m7),
    .ce_5m37(ce_5m37),
    .ce_cpu(ce_cpu),
    .ce_1m79(ce_1m79),
    .state_o(state_o)
  );

  typedef struct packed {
    int         cyc;
    logic       sr;
    logic       sy;
    logic [3:0] ce;   // {10m7, 5m37, cpu, 1m79}
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Input history per cycle since reset release, and model state.
  logic lk_h [MAXC];
  logic bt_h [MAXC];
  logic dn_h [MAXC];
  logic tu_h [MAXC];
  int cur;       // cycle index whose inputs are being driven
  int phase;     // 0 lock wait, 1 sdram wait, 2 run
  int t_phase;   // cycle the current phase started
  int last_low;  // last cycle with synchronized lock low
  int last_btn;  // last run cycle with synchronized button high

  // Monitor-side measurements
  int first_sr_low, first_sy_low;
  int win_lo = -1, win_hi = -1;
  int cnt10, cnt5, cntcpu, cnt1, coin_bad, adj_bad;
  logic prev_cpu = 1'b0;

  function automatic logic lk_s(input int c);
    return (c >= 2) ? lk_h[c-2] : 1'b0;
  endfunction

  function automatic logic bt_s(input int c);
    return (c >= 2) ? bt_h[c-2] : 1'b0;
  endfunction

  function automatic exp_t make_exp(input int c);
    exp_t e;
    int w;
    logic tmode;
    e = '0;
    e.cyc = c;
    e.st = 2'(phase);
    e.sr = (phase == 0);
    e.sy = (phase != 2) || ((c - last_btn >= 1) && (c - last_btn <= BST));
    if (phase == 2) begin
      w = (c - t_phase) % 12;
      tmode = 1'b0;
`ifdef MSX_TURBO_EN
      // Mode for the whole window is the synchronized turbo at its start.
      tmode = tu_h[c - w - 2];
`endif
      e.ce[3] = (w % 2 == 0);
      e.ce[2] = (w % 4 == 0);
      e.ce[1] = tmode ? (w % 3 == 0) : (w % 6 == 0);
      e.ce[0] = (w == 0);
    end
    return e;
  endfunction

  task automatic model_reset();
    cur = 0;
    phase = 0;
    t_phase = 0;
    last_low = -1;
    last_btn = -1000;
    exp_q.push_back(make_exp(0));
  endtask

  task automatic model_advance();
    int p, nphase, start;
    logic sp;
    p = cur;
    sp = lk_s(p);
    if (!sp) last_low = p;
    if (phase == 2 && bt_s(p)) last_btn = p;
    nphase = phase;
    case (phase)
      0: begin
        start = (t_phase > last_low + 1) ? t_phase : last_low + 1;
        if (sp && (p - start + 1 >= LSC)) nphase = 1;
      end
      1: begin
        if (!sp) nphase = 0;
        else if (dn_h[p] || (p - t_phase == TMO)) nphase = 2;
      end
      default: begin
        if (!sp) nphase = 0;
      end
    endcase
    cur = p + 1;
    if (nphase != phase) begin
      phase = nphase;
      t_phase = cur;
      last_btn = -1000;
    end
    exp_q.push_back(make_exp(cur));
  endtask

  task automatic do_reset(input int n, input logic l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      pll_locked = l;
      reset_button = 1'b0;
      sdram_init_done = 1'b0;
      model_reset();
    end
  endtask

  task automatic drive(input logic l, input logic b, input logic d, input logic t);
    @(negedge clk);
    rst = 1'b0;
    pll_locked = l;
    reset_button = b;
    sdram_init_done = d;
`ifdef MSX_TURBO_EN
    turbo = t;
`endif
    lk_h[cur] = l;
    bt_h[cur] = b;
    dn_h[cur] = d;
    tu_h[cur] = t;
    model_advance();
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_counts();
    cnt10 = 0; cnt5 = 0; cntcpu = 0; cnt1 = 0; coin_bad = 0; adj_bad = 0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [3:0] ce_got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ce_got = {ce_10m7, ce_5m37, ce_cpu, ce_1m79};
        vectors++;
        if (sdram_reset !== e.sr || sys_reset !== e.sy || ce_got !== e.ce || state_o !== e.st) begin
          miscompares++;
          $display("FAIL vec cyc=%0d got sr=%b sy=%b ce=%b st=%0d want sr=%b sy=%b ce=%b st=%0d",
                   e.cyc, sdram_reset, sys_reset, ce_got, state_o, e.sr, e.sy, e.ce, e.st);
        end
        if (e.cyc == 0) begin
          first_sr_low = -1;
          first_sy_low = -1;
        end else begin
          if (!sdram_reset && first_sr_low < 0) first_sr_low = e.cyc;
          if (!sys_reset && first_sy_low < 0) first_sy_low = e.cyc;
        end
        if (e.cyc >= win_lo && e.cyc <= win_hi) begin
          cnt10  += int'(ce_10m7);
          cnt5   += int'(ce_5m37);
          cntcpu += int'(ce_cpu);
          cnt1   += int'(ce_1m79);
          if (ce_1m79 && !(ce_cpu && ce_5m37 && ce_10m7)) coin_bad++;
          if (ce_cpu && prev_cpu) adj_bad++;
        end
        prev_cpu = ce_cpu;
      end
    end
  end

  // Stimulus
  initial begin
    int done_at, low, bhold;
    logic tv;

    // Power-up: lock from cycle 0, init done on 5th SDRAM_WAIT cycle.
    clear_counts();
    win_lo = 15;
    win_hi = 134;
    do_reset(5, 1'b1);
    for (int i = 0; i < 140; i++) drive(1'b1, 1'b0, (cur >= 14), 1'b0);
    check("pwr_sdram_fall", first_sr_low, 10);
    check("pwr_sys_fall", first_sy_low, 15);
    check("cnt_ce_10m7", cnt10, 60);
    check("cnt_ce_5m37", cnt5, 30);
    check("cnt_ce_cpu", cntcpu, 20);
    check("cnt_ce_1m79", cnt1, 10);
    check("ce_coincide_bad", coin_bad, 0);
    win_lo = -1;
    win_hi = -1;

    // Button: single-cycle pulse, then held 50 cycles.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    // Lock loss in RUN, then recovery.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);

    // Timeout path: init done never arrives.
    do_reset(3, 1'b1);
    for (int i = 0; i < 45; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo_sdram_fall", first_sr_low, 10);
    check("tmo_sys_fall", first_sy_low, 31);

    // Lock glitch at stable count 5.
    do_reset(3, 1'b1);
    for (int i = 0; i < 30; i++) drive((cur != 5), 1'b0, 1'b1, 1'b0);
    check("glitch_sdram_fall", first_sr_low, 16);
    check("glitch_sys_fall", first_sy_low, 17);

`ifdef MSX_TURBO_EN
    // Steady turbo, then toggles at div==7.
    clear_counts();
    win_lo = 11;
    win_hi = 130;
    do_reset(3, 1'b1);
    for (int i = 0; i < 135; i++) drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("turbo_cnt_cpu", cntcpu, 40);
    check("turbo_cnt_1m79", cnt1, 10);
    check("turbo_adjacent", adj_bad, 0);
    win_lo = -1;
    win_hi = -1;
    tv = 1'b1;
    for (int i = 0; i < 72; i++) begin
      if ((cur - 11) % 12 == 7) tv = ~tv;
      drive(1'b1, 1'b0, 1'b1, tv);
    end
`endif

    // Randomized segments.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset(1 + int'($urandom_range(2)), 1'($urandom_range(1)));
      done_at = int'($urandom_range(10, 60));
      if (seg % 3 == 2) done_at = 100000;
      low = 0;
      bhold = 0;
      tv = 1'($urandom_range(1));
      for (int i = 0; i < 400; i++) begin
        if (low == 0 && $urandom_range(249) == 0) low = int'($urandom_range(1, 4));
        if (bhold == 0 && $urandom_range(39) == 0) bhold = int'($urandom_range(1, 8));
        if ($urandom_range(29) == 0) tv = ~tv;
        drive((low == 0), (bhold != 0), (cur >= done_at), tv);
        if (low > 0) low--;
        if (bhold > 0) bhold--;
      end
    end

    // Drain the scoreboard.
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
